// File: rtl/bit_deserializer.sv
// bit_deserializer: assembles framed serial bits into WIDTH-bit words with a one-deep output register.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_n;
  logic [WIDTH-1:0] sh_q, sh_d, base, shifted, dout_q, dout_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic             start, cap, done, load;
  always_comb begin
    start   = din_en && sof;
    cap     = din_en && (sof || state_q == SHIFT);
    // a fresh sof throws away any partial frame before shifting in bit 1
    base    = start ? '0 : sh_q;
    shifted = (MSB_FIRST != 0) ? {base[WIDTH-2:0], din} : {din, base[WIDTH-1:1]};
    cnt_n   = start ? CW'(1) : cnt_q + CW'(1);
    done    = cap && cnt_n == LAST;
    load    = done && (!valid_q || dout_ready);
    state_d = cap ? (done ? IDLE : SHIFT) : state_q;
    cnt_d   = cap ? (done ? '0 : cnt_n) : cnt_q;
    sh_d    = cap ? shifted : sh_q;
    dout_d  = load ? shifted : dout_q;
    valid_d = load || (valid_q && !dout_ready);
    ovf_d   = ovf_q || (done && valid_q && !dout_ready);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overflow   = ovf_q;
  assign busy       = state_q == SHIFT;
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: directed checks of framing, handshake, overflow and bit order.
module tb_bit_deserializer;
  logic       clk = 1'b0;
  logic       clr = 1'b0, din = 1'b0, din_en = 1'b0, sof = 1'b0, dout_ready = 1'b0;
  logic [7:0] dout, dout_l;
  logic       dout_valid, overflow, busy, dout_valid_l, overflow_l, busy_l;
  int         tests = 0, fails = 0, vcnt = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .clr(clr), .din(din), .din_en(din_en), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overflow(overflow), .busy(busy)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .clr(clr), .din(din), .din_en(din_en), .sof(sof),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .overflow(overflow_l), .busy(busy_l)
  );

  always @(negedge clk) if (dout_valid) vcnt++;

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    din = b; sof = s; din_en = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_en = 1'b0; sof = 1'b0; din = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
  endtask

  task automatic do_clr();
    @(negedge clk);
    din_en = 1'b0; sof = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1; din_en = 1'b1; sof = 1'b1; din = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({dout, dout_valid, overflow, busy} !== 11'h000) begin
      fails++; $display("FAIL reset_outputs got dout=%h v=%b ovf=%b busy=%b exp all 0", dout, dout_valid, overflow, busy);
    end
    clr = 1'b0; din_en = 1'b0; sof = 1'b0; din = 1'b0;
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    vcnt = 0;
    send_word(8'hB2);
    idle();
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'hB2) begin
      fails++; $display("FAIL basic_word got dout=%h v=%b exp B2 v=1", dout, dout_valid);
    end
    tests++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_flags got ovf=%b busy=%b exp 0 0", overflow, busy);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dout_valid !== 1'b0 || vcnt != 1) begin
      fails++; $display("FAIL basic_one_cycle got v=%b cycles=%0d exp v=0 cycles=1", dout_valid, vcnt);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    dout_ready = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    idle();
    tests++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
      fails++; $display("FAIL ovf_hold got dout=%h v=%b exp A5 v=1", dout, dout_valid);
    end
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_set got %b exp 1", overflow);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_drain got v=%b ovf=%b exp v=0 ovf=1", dout_valid, overflow);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    dout_ready = 1'b1;
    vcnt = 0;
    send_word(8'h5A);
    send_word(8'hC3);
    idle();
    tests++;
    if (dout !== 8'hC3 || dout_valid !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL b2b_second got dout=%h v=%b ovf=%b exp C3 1 0", dout, dout_valid, overflow);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (vcnt != 2) begin
      fails++; $display("FAIL b2b_words got %0d valid cycles exp 2", vcnt);
    end
  endtask

  task automatic test_restart();
    do_clr();
    dout_ready = 1'b1;
    vcnt = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'hFF);
    idle();
    tests++;
    if (dout !== 8'hFF || dout_valid !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL restart_word got dout=%h v=%b ovf=%b exp FF 1 0", dout, dout_valid, overflow);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (vcnt != 1) begin
      fails++; $display("FAIL restart_single got %0d valid cycles exp 1", vcnt);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    int bad;
    do_clr();
    dout_ready = 1'b1;
    w = 8'h81;
    bad = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      if (i > 0) begin
        idle();
        idle();
        if (busy !== 1'b1) bad++;
      end
    end
    idle();
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL gaps_busy got %0d idle cycles with busy=0 exp 0", bad);
    end
    tests++;
    if (dout !== 8'h81 || dout_valid !== 1'b1) begin
      fails++; $display("FAIL gaps_word got dout=%h v=%b exp 81 v=1", dout, dout_valid);
    end
  endtask

  task automatic test_clr_mid();
    logic [7:0] w;
    do_clr();
    dout_ready = 1'b1;
    w = 8'hE7;
    for (int i = 7; i >= 3; i--) send_bit(w[i], i == 7);
    do_clr();
    tests++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      fails++; $display("FAIL clr_mid got busy=%b v=%b exp 0 0", busy, dout_valid);
    end
    send_word(8'h0F);
    idle();
    tests++;
    if (dout !== 8'h0F || dout_valid !== 1'b1) begin
      fails++; $display("FAIL clr_next_word got dout=%h v=%b exp 0F v=1", dout, dout_valid);
    end
  endtask

  task automatic test_lsb_first();
    do_clr();
    dout_ready = 1'b1;
    send_word(8'h80);
    idle();
    tests++;
    if (dout_l !== 8'h01 || dout_valid_l !== 1'b1) begin
      fails++; $display("FAIL lsb_first got dout=%h v=%b exp 01 v=1", dout_l, dout_valid_l);
    end
    tests++;
    if (dout !== 8'h80) begin
      fails++; $display("FAIL msb_first_same_bits got dout=%h exp 80", dout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_restart();
    test_gaps();
    test_clr_mid();
    test_lsb_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the assembled word width; legal range 2..32.
REQ-002 The module SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in dout[WIDTH-1], 0 = first received bit lands in dout[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset; synchronous, active-high.
REQ-005 din  input  1  serial data bit from the upstream flip-flop stage.
REQ-006 din_en  input  1  din is valid this cycle.
REQ-007 sof  input  1  start of frame; meaningful only when din_en=1.
REQ-008 dout  output  WIDTH  assembled word.
REQ-009 dout_valid  output  1  dout holds an unconsumed word.
REQ-010 dout_ready  input  1  downstream accepts dout.
REQ-011 overflow  output  1  sticky flag: a completed word was dropped.
REQ-012 busy  output  1  frame in progress (state SHIFT).

Function
REQ-013 The module SHALL implement a two-state FSM, IDLE and SHIFT, with bit counter cnt (0..WIDTH) and a WIDTH-bit shift register.
REQ-014 In IDLE, din_en=1 with sof=1 SHALL capture din as bit 1 of a frame, set cnt=1 and move to SHIFT.
REQ-015 In IDLE, din_en=1 with sof=0 SHALL be ignored.
REQ-016 In SHIFT, din_en=1 with sof=0 SHALL capture din and increment cnt.
REQ-017 In SHIFT, din_en=1 with sof=1 SHALL discard the partial frame without setting overflow and restart with din as bit 1 (cnt=1).
REQ-018 din_en=0 SHALL hold state, cnt and the shift register.
REQ-019 With MSB_FIRST=1, each captured bit SHALL enter at the LSB and shift left; with MSB_FIRST=0, it SHALL enter at the MSB and shift right.
REQ-020 When the WIDTH-th bit is captured, the word SHALL be complete: the FSM returns to IDLE and cnt returns to 0 on that edge.
REQ-021 On completion, if dout_valid=0 or (dout_valid=1 and dout_ready=1) at that edge, dout SHALL load the word and dout_valid SHALL be 1 in the following cycle (latency 1 cycle after the edge capturing the last bit).
REQ-022 On completion with dout_valid=1 and dout_ready=0, the word SHALL be dropped, dout SHALL remain unchanged, and overflow SHALL be set to 1.
REQ-023 A transfer SHALL occur on each edge where dout_valid=1 and dout_ready=1; dout_valid SHALL then clear unless a new word loads on the same edge.
REQ-024 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-025 overflow SHALL remain 1 until clr.
REQ-026 IDLE SHALL accept sof in the cycle immediately after completion, allowing back-to-back frames without a gap cycle.
REQ-027 busy SHALL equal 1 exactly when the state is SHIFT.
REQ-028 dout_ready SHALL be ignored when dout_valid=0.

Reset
REQ-029 On a rising edge with clr=1, the module SHALL set state=IDLE, cnt=0, shift register=0, dout=0, dout_valid=0, overflow=0 and busy=0.
REQ-030 clr SHALL take priority over din_en, sof and dout_ready on the same edge.
REQ-031 clr SHALL silently discard any partial frame and any pending unconsumed word.

Verification
REQ-032 After clr, drive sof+din_en on bit 1, then din_en on consecutive cycles with bits 1,0,1,1,0,0,1,0 and dout_ready=1 -> dout=8'hB2 and dout_valid=1 for exactly one cycle, starting the cycle after the last bit; overflow=0.
REQ-033 With dout_ready=0, send frames 8'hA5 then 8'h3C -> dout stays 8'hA5 and overflow=1 after the second completion; then raise dout_ready -> dout_valid=0 next cycle and overflow stays 1.
REQ-034 Send 3 bits of a frame, then sof with 8 bits of 8'hFF -> single word 8'hFF; overflow=0.
REQ-035 Send 8'h81 with din_en=0 idle cycles between bits -> dout=8'h81 with busy=1 throughout the frame.
REQ-036 Assert clr after 5 bits of a frame -> busy=0 next cycle and no dout_valid; a following frame 8'h0F is received correctly.
REQ-037 With MSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 -> dout=8'h01.
